rr_arbiter_16: RTL and testbench



---
 rtl/rr_arbiter_16_if.sv | 31 +++
 rtl/rr_arbiter_16.sv | 111 +++++++++++
 tb/tb_rr_arbiter_16.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_16_if.sv
// Requester/downstream bundle for the 16-way round-robin arbiter.
//   req, req_last : per-requester request level and last-beat flag
//   gnt, gnt_idx  : registered one-hot grant and its binary index
//   gnt_valid     : granted requester is presenting a beat
//   gnt_last      : presented beat is the last of its transaction
//   gnt_ready     : downstream accepts the current beat
//   err           : sticky protocol-violation flag
// master = requesters/downstream side, slave = arbiter side.
interface rr_arbiter_16_if #(
  parameter int NREQ = 16,
  parameter int IDW  = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_valid;
  logic            gnt_last;
  logic            gnt_ready;
  logic            err;

  modport master (
    output req, req_last, gnt_ready,
    input  gnt, gnt_idx, gnt_valid, gnt_last, err
  );

  modport slave (
    input  req, req_last, gnt_ready,
    output gnt, gnt_idx, gnt_valid, gnt_last, err
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter sharing one downstream resource among 16 requesters.
// The grant is held for a whole multi-beat transaction and priority rotates
// to the requester after the one just served.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : rr_arbiter_16_if.slave (req/req_last in, gnt/gnt_idx/gnt_valid/
//            gnt_last/err out, gnt_ready in)
module rr_arbiter_16 #(
  parameter int NREQ = 16,
  parameter int IDW  = 4
) (
  input  logic           clk,
  input  logic           resetn,
  rr_arbiter_16_if.slave bus
);

  if (NREQ != 16 || IDW != 4) begin : g_bad_params
    $error("rr_arbiter_16 supports only NREQ=16, IDW=4");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  idx_q, idx_d;
  logic [IDW-1:0]  ptr, ptr_d;
  logic            err_q, err_d;

  logic            sel_found;
  logic [IDW-1:0]  sel_idx;
  logic [IDW-1:0]  cand;
  logic            gnt_valid;
  logic            gnt_last;
  logic            accept;

  // Circular priority scan: first set request starting at ptr, wrapping
  // naturally through the 4-bit addition.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + IDW'(i);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign gnt_valid = (state_q == BUSY) & bus.req[idx_q];
  assign gnt_last  = gnt_valid & bus.req_last[idx_q];
  assign accept    = gnt_valid & bus.gnt_ready;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (sel_found) begin
          gnt_d[sel_idx] = 1'b1;
          idx_d          = sel_idx;
          state_d        = BUSY;
        end
      end
      BUSY: begin
        // A dropped request while granted abandons the transaction and
        // advances priority exactly as a normal release would.
        if (!bus.req[idx_q]) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = idx_q + IDW'(1);
          state_d = IDLE;
        end else if (accept && gnt_last) begin
          gnt_d   = '0;
          ptr_d   = idx_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr     <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = gnt_valid;
  assign bus.gnt_last  = gnt_last;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
module tb_rr_arbiter_16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  rr_arbiter_16_if #(.NREQ(16), .IDW(4)) bif ();

  rr_arbiter_16 #(.NREQ(16), .IDW(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic [15:0] prev_gnt = '0;

  // Scoreboard monitor: every new grant must match the next expected index;
  // one-hot and index/grant consistency are checked every cycle.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(bif.gnt)) begin
      errors++;
      $display("FAIL inv_onehot gnt=%h required one-hot or zero", bif.gnt);
    end
    if (bif.gnt != 16'h0) begin
      checks++;
      if (bif.gnt !== (16'h1 << bif.gnt_idx)) begin
        errors++;
        $display("FAIL inv_idx gnt=%h gnt_idx=%0d required matching", bif.gnt, bif.gnt_idx);
      end
    end
    if (bif.gnt != 16'h0 && prev_gnt == 16'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected gnt_idx=%0d required no grant", bif.gnt_idx);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (bif.gnt_idx !== 4'(e)) begin
          errors++;
          $display("FAIL sb_order gnt_idx=%0d required %0d", bif.gnt_idx, e);
        end
      end
    end
    prev_gnt = bif.gnt;
  end

  task automatic do_reset();
    bif.req = '0;
    bif.req_last = '0;
    bif.gnt_ready = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    bif.req = '0;
    bif.req_last = '0;
    bif.gnt_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0) begin errors++; $display("FAIL rst_gnt got=%h exp=0000", bif.gnt); end
    checks++;
    if (bif.gnt_idx !== 4'd0) begin errors++; $display("FAIL rst_idx got=%0d exp=0", bif.gnt_idx); end
    checks++;
    if (bif.gnt_valid !== 1'b0 || bif.gnt_last !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%b/%b exp=0/0", bif.gnt_valid, bif.gnt_last);
    end
    checks++;
    if (bif.err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", bif.err); end
    checks++;
    if (dut.ptr !== 4'd0) begin errors++; $display("FAIL rst_ptr got=%0d exp=0", dut.ptr); end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    bif.req = 16'h0001;
    bif.req_last = 16'h0001;
    bif.gnt_ready = 1'b1;
    exp_q.push_back(0);
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0001 || bif.gnt_idx !== 4'd0) begin
      errors++; $display("FAIL single_gnt got=%h/%0d exp=0001/0", bif.gnt, bif.gnt_idx);
    end
    checks++;
    if (bif.gnt_valid !== 1'b1 || bif.gnt_last !== 1'b1) begin
      errors++; $display("FAIL single_valid got=%b/%b exp=1/1", bif.gnt_valid, bif.gnt_last);
    end
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0) begin errors++; $display("FAIL single_release got=%h exp=0000", bif.gnt); end
    checks++;
    if (dut.ptr !== 4'd1) begin errors++; $display("FAIL single_ptr got=%0d exp=1", dut.ptr); end
    bif.req = '0;
    bif.req_last = '0;
  endtask

  task automatic test_all_requesters();
    do_reset();
    bif.req = 16'hFFFF;
    bif.req_last = 16'hFFFF;
    bif.gnt_ready = 1'b1;
    for (int k = 0; k <= 16; k++) exp_q.push_back(k % 16);
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      checks++;
      if (j % 2 == 1) begin
        int e;
        e = ((j - 1) / 2) % 16;
        if (bif.gnt !== (16'h1 << e) || bif.gnt_idx !== 4'(e) || bif.gnt_valid !== 1'b1) begin
          errors++;
          $display("FAIL all_grant cyc=%0d got=%h/%0d/%b exp=%h/%0d/1", j, bif.gnt, bif.gnt_idx,
                   bif.gnt_valid, 16'h1 << e, e);
        end
      end else begin
        if (bif.gnt !== 16'h0) begin
          errors++; $display("FAIL all_bubble cyc=%0d got=%h exp=0000", j, bif.gnt);
        end
      end
    end
    bif.req = '0;
    checks++;
    if (dut.ptr !== 4'd1) begin errors++; $display("FAIL all_ptr got=%0d exp=1", dut.ptr); end
  endtask

  task automatic test_wrap();
    do_reset();
    bif.req = 16'h4000;
    bif.req_last = 16'hFFFF;
    bif.gnt_ready = 1'b1;
    exp_q.push_back(14);
    exp_q.push_back(15);
    exp_q.push_back(0);
    repeat (2) @(negedge clk);
    checks++;
    if (dut.ptr !== 4'd15) begin errors++; $display("FAIL wrap_ptr15 got=%0d exp=15", dut.ptr); end
    bif.req = 16'h8001;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h8000 || bif.gnt_idx !== 4'd15) begin
      errors++; $display("FAIL wrap_gnt15 got=%h/%0d exp=8000/15", bif.gnt, bif.gnt_idx);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0001 || bif.gnt_idx !== 4'd0) begin
      errors++; $display("FAIL wrap_gnt0 got=%h/%0d exp=0001/0", bif.gnt, bif.gnt_idx);
    end
    @(negedge clk);
    checks++;
    if (dut.ptr !== 4'd1) begin errors++; $display("FAIL wrap_ptr1 got=%0d exp=1", dut.ptr); end
    bif.req = '0;
  endtask

  task automatic test_multibeat();
    logic [0:4] rdy_seq;
    do_reset();
    bif.req = 16'h0028;
    bif.req_last = 16'h0020;
    bif.gnt_ready = 1'b1;
    rdy_seq = 5'b10101;
    exp_q.push_back(3);
    exp_q.push_back(5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bif.gnt !== 16'h0008 || bif.gnt_valid !== 1'b1) begin
        errors++; $display("FAIL mb_hold cyc=%0d got=%h/%b exp=0008/1", c, bif.gnt, bif.gnt_valid);
      end
      if (c == 0 || c == 4) begin
        checks++;
        if (bif.gnt_last !== (c == 4)) begin
          errors++; $display("FAIL mb_last cyc=%0d got=%b exp=%b", c, bif.gnt_last, c == 4);
        end
      end
      bif.gnt_ready = rdy_seq[c];
      if (c == 3) bif.req_last = 16'h0028;
    end
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0 || dut.ptr !== 4'd4) begin
      errors++; $display("FAIL mb_release got=%h/%0d exp=0000/4", bif.gnt, dut.ptr);
    end
    bif.req = 16'h0020;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0020 || bif.gnt_idx !== 4'd5) begin
      errors++; $display("FAIL mb_next got=%h/%0d exp=0020/5", bif.gnt, bif.gnt_idx);
    end
    @(negedge clk);
    bif.req = '0;
    bif.req_last = '0;
  endtask

  task automatic test_violation();
    do_reset();
    bif.req = 16'h0004;
    bif.req_last = 16'h0000;
    bif.gnt_ready = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(4);
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0004) begin errors++; $display("FAIL viol_gnt got=%h exp=0004", bif.gnt); end
    @(negedge clk);
    bif.req = 16'h0000;
    bif.req_last = 16'h0004;
    #1;
    checks++;
    if (bif.gnt_valid !== 1'b0 || bif.gnt_last !== 1'b0) begin
      errors++; $display("FAIL viol_valid got=%b/%b exp=0/0", bif.gnt_valid, bif.gnt_last);
    end
    @(negedge clk);
    checks++;
    if (bif.err !== 1'b1 || bif.gnt !== 16'h0 || dut.ptr !== 4'd3) begin
      errors++; $display("FAIL viol_flag got=%b/%h/%0d exp=1/0000/3", bif.err, bif.gnt, dut.ptr);
    end
    bif.req = 16'h0010;
    bif.req_last = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0010 || bif.err !== 1'b1) begin
      errors++; $display("FAIL viol_sticky got=%h/%b exp=0010/1", bif.gnt, bif.err);
    end
    @(negedge clk);
    bif.req = '0;
    checks++;
    if (bif.err !== 1'b1) begin errors++; $display("FAIL viol_sticky2 got=%b exp=1", bif.err); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    bif.req = 16'h0400;
    bif.req_last = 16'h0000;
    bif.gnt_ready = 1'b0;
    exp_q.push_back(10);
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0400 || bif.gnt_valid !== 1'b1 || bif.err !== 1'b1) begin
      errors++; $display("FAIL rb_pre got=%h/%b/%b exp=0400/1/1", bif.gnt, bif.gnt_valid, bif.err);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bif.gnt !== 16'h0 || bif.gnt_valid !== 1'b0 || bif.err !== 1'b0 || bif.gnt_idx !== 4'd0) begin
      errors++; $display("FAIL rb_async got=%h/%b/%b/%0d exp=0000/0/0/0", bif.gnt, bif.gnt_valid,
                         bif.err, bif.gnt_idx);
    end
    exp_q.push_back(10);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 16'h0400 || bif.gnt_idx !== 4'd10 || dut.ptr !== 4'd0) begin
      errors++; $display("FAIL rb_regrant got=%h/%0d/%0d exp=0400/10/0", bif.gnt, bif.gnt_idx, dut.ptr);
    end
    bif.req_last = 16'h0400;
    bif.gnt_ready = 1'b1;
    @(negedge clk);
    bif.req = '0;
    checks++;
    if (dut.ptr !== 4'd11 || bif.gnt !== 16'h0) begin
      errors++; $display("FAIL rb_release got=%h/%0d exp=0000/11", bif.gnt, dut.ptr);
    end
  endtask

  initial begin
    bif.req = '0;
    bif.req_last = '0;
    bif.gnt_ready = 1'b0;
    test_reset();
    test_single();
    test_all_requesters();
    test_wrap();
    test_multibeat();
    test_violation();
    test_reset_busy();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
